echo_delay_fifo: RTL and testbench

//  Multi-channel circular delay line for the echo effect path; supersedes the single-stream echo FIFO.

---
 rtl/echo_delay_fifo_pkg.sv | 24 ++
 rtl/echo_delay_fifo_ram.sv | 34 +++
 rtl/echo_delay_fifo.sv | 196 +++++++++++++++++++
 tb/tb_echo_delay_fifo.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/echo_delay_fifo_pkg.sv
// Package echo_pkg: shared types and helpers for the echo delay line.
//   state_t  : line state (IDLE / FILL / RUN)
//   sat_add  : signed add clamped to a w-bit signed range. Used when the
//              feedback path is built in (ECHO_DELAY_FEEDBACK_EN).
package echo_pkg;

    typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

    // a and b are sign-extended samples, so the 33-bit sum cannot wrap.
    function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                   input logic signed [31:0] b,
                                                   input int unsigned        w);
        logic signed [32:0] s;
        logic signed [32:0] hi;
        logic signed [32:0] lo;
        s  = 33'(a) + 33'(b);
        hi = (33'sd1 <<< (w - 1)) - 33'sd1;
        lo = -(33'sd1 <<< (w - 1));
        if (s > hi)      return 32'(hi);
        else if (s < lo) return 32'(lo);
        return 32'(s);
    endfunction

endpackage

// File: rtl/echo_delay_fifo_ram.sv
// echo_ram: simple dual-port sample store, one write port and one
// registered read port. The array has no reset.
//   i_clk           clock
//   i_we/i_waddr/i_wdata   write port
//   i_re/i_raddr    read request; o_rdata updates the cycle after i_re
//   o_rdata         read data, held while i_re is low
module echo_ram #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [1<<ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    // Read-enable gating keeps the output stable while the consumer stalls.
    always_ff @(posedge i_clk) begin
        if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/echo_delay_fifo.sv
// echo_delay_fifo: multi-channel circular delay line for the echo path.
// Frame-interleaved samples go in; each comes back one cycle after accept,
// delayed by D = min(pi_delay*NUM_CH, MEM_DEPTH-NUM_CH) samples.
//   pi_clk, pi_rst_n (async, active low)
//   pi_flush     soft restart: drops same-cycle input, clears pointers
//   pi_delay     delay in frames, sampled while IDLE
//   pi_valid/pi_data/po_in_ready     input stream
//   po_valid/po_data/po_ch/pi_out_ready  output stream
// Optional build macro ECHO_DELAY_FEEDBACK_EN: stored value becomes
// sat(x + (y >>> FB_SHIFT)) with the write deferred by one cycle and
// forwarded to a colliding read; delay of zero frames is promoted to one.
module echo_delay_fifo
    import echo_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int MEM_DEPTH  = 1024,
    parameter int NUM_CH     = 2,
    parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
    parameter int CH_WIDTH   = ($clog2(NUM_CH) > 0) ? $clog2(NUM_CH) : 1,
    parameter int FB_SHIFT   = 1
) (
    input  logic                  pi_clk,
    input  logic                  pi_rst_n,
    input  logic                  pi_flush,
    input  logic [ADDR_WIDTH-1:0] pi_delay,
    input  logic                  pi_valid,
    input  logic [DATA_WIDTH-1:0] pi_data,
    output logic                  po_in_ready,
    output logic                  po_valid,
    output logic [DATA_WIDTH-1:0] po_data,
    output logic [CH_WIDTH-1:0]   po_ch,
    input  logic                  pi_out_ready
);

    localparam int unsigned D_MAX = MEM_DEPTH - NUM_CH;

    state_t                r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_wr_ptr, r_rd_ptr, r_fill_cnt, r_d;
    logic [ADDR_WIDTH-1:0] w_d_calc, w_d;
    logic [CH_WIDTH-1:0]   r_ch, r_out_ch;
    logic                  r_valid, r_src_ram;
    logic [DATA_WIDTH-1:0] r_hold;
    logic [31:0]           w_delay_eff, w_prod;
    logic                  w_acc, w_fill_beh, w_bypass, w_fill_last, w_fwd;
    logic                  w_ram_we, w_ram_re;
    logic [ADDR_WIDTH-1:0] w_ram_waddr;
    logic [DATA_WIDTH-1:0] w_ram_wdata, w_ram_rdata;

    // ---- delay in samples -------------------------------------------------
`ifdef ECHO_DELAY_FEEDBACK_EN
    assign w_delay_eff = (pi_delay == '0) ? 32'd1 : 32'(pi_delay);
`else
    assign w_delay_eff = 32'(pi_delay);
`endif
    assign w_prod   = w_delay_eff * 32'(NUM_CH);
    assign w_d_calc = (w_prod > 32'(D_MAX)) ? ADDR_WIDTH'(D_MAX) : ADDR_WIDTH'(w_prod);
    // The first accept happens in IDLE, so it must see the live value.
    assign w_d      = (r_state == IDLE) ? w_d_calc : r_d;

    // ---- handshake --------------------------------------------------------
    assign po_in_ready = !pi_flush && (!r_valid || pi_out_ready);
    assign w_acc       = pi_valid && po_in_ready;
    assign w_fill_last = (r_fill_cnt + 1'b1) == w_d;

    // ---- FSM --------------------------------------------------------------
    always_ff @(posedge pi_clk or negedge pi_rst_n) begin
        if (!pi_rst_n) r_state <= IDLE;
        else           r_state <= w_state_nxt;
    end

    // The IDLE accept already behaves as a FILL (or bypass) accept.
    always_comb begin
        w_state_nxt = r_state;
        w_fill_beh  = 1'b0;
        w_bypass    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_d == '0) begin
                    w_bypass = 1'b1;
                    if (w_acc) w_state_nxt = RUN;
                end else begin
                    w_fill_beh = 1'b1;
                    if (w_acc) w_state_nxt = w_fill_last ? RUN : FILL;
                end
            end
            FILL: begin
                w_fill_beh = 1'b1;
                if (w_acc && w_fill_last) w_state_nxt = RUN;
            end
            RUN:     w_bypass    = (r_d == '0);
            default: w_state_nxt = IDLE;
        endcase
        if (pi_flush) w_state_nxt = IDLE;
    end

    // ---- storage write path -----------------------------------------------
`ifdef ECHO_DELAY_FEEDBACK_EN
    logic                         r_pend_vld;
    logic [ADDR_WIDTH-1:0]        r_pend_addr;
    logic signed [DATA_WIDTH-1:0] r_pend_x, w_y;

    // y of an accept is exactly what po_data shows the following cycle.
    assign w_y         = po_data;
    assign w_ram_wdata = DATA_WIDTH'(sat_add(32'(r_pend_x), 32'(w_y >>> FB_SHIFT), DATA_WIDTH));
    assign w_ram_we    = r_pend_vld;
    assign w_ram_waddr = r_pend_addr;
    assign w_fwd       = r_pend_vld && (r_pend_addr == r_rd_ptr);

    always_ff @(posedge pi_clk or negedge pi_rst_n) begin
        if (!pi_rst_n) begin
            r_pend_vld  <= 1'b0;
            r_pend_addr <= '0;
            r_pend_x    <= '0;
        end else begin
            r_pend_vld <= w_acc;
            if (w_acc) begin
                r_pend_addr <= r_wr_ptr;
                r_pend_x    <= pi_data;
            end
        end
    end
`else
    assign w_ram_wdata = pi_data;
    assign w_ram_we    = w_acc;
    assign w_ram_waddr = r_wr_ptr;
    assign w_fwd       = 1'b0;
`endif

    assign w_ram_re = w_acc && !w_fill_beh && !w_bypass;

    echo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .i_clk   (pi_clk),
        .i_we    (w_ram_we),
        .i_waddr (w_ram_waddr),
        .i_wdata (w_ram_wdata),
        .i_re    (w_ram_re),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_ram_rdata)
    );

    // ---- pointers, counters, output register ------------------------------
    always_ff @(posedge pi_clk or negedge pi_rst_n) begin
        if (!pi_rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fill_cnt <= '0;
            r_d        <= '0;
            r_ch       <= '0;
            r_out_ch   <= '0;
            r_valid    <= 1'b0;
            r_hold     <= '0;
            r_src_ram  <= 1'b0;
        end else begin
            if (r_state == IDLE) r_d <= w_d_calc;
            if (pi_flush) begin
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_fill_cnt <= '0;
                r_ch       <= '0;
                r_valid    <= 1'b0;
            end else if (w_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                r_ch     <= (r_ch == CH_WIDTH'(NUM_CH - 1)) ? '0 : r_ch + 1'b1;
                r_valid  <= 1'b1;
                r_out_ch <= r_ch;
                if (w_fill_beh) begin
                    r_fill_cnt <= r_fill_cnt + 1'b1;
                    r_hold     <= '0;
                    r_src_ram  <= 1'b0;
                end else begin
                    // rd_ptr tracks wr_ptr - D, including the D=0 case.
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                    if (w_bypass) begin
                        r_hold    <= pi_data;
                        r_src_ram <= 1'b0;
                    end else if (w_fwd) begin
                        r_hold    <= w_ram_wdata;
                        r_src_ram <= 1'b0;
                    end else begin
                        r_src_ram <= 1'b1;
                    end
                end
            end else if (pi_out_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign po_valid = r_valid;
    assign po_ch    = r_out_ch;
    assign po_data  = r_src_ram ? w_ram_rdata : r_hold;

endmodule

// File: tb/tb_echo_delay_fifo.sv
module tb_echo_delay_fifo;

    localparam int DW  = 16;
    localparam int MD  = 64;
    localparam int NCH = 2;
    localparam int AW  = 6;
    localparam int CHW = 1;
    localparam int FB  = 1;

    logic           pi_clk = 1'b0;
    logic           pi_rst_n = 1'b0;
    logic           pi_flush = 1'b0;
    logic [AW-1:0]  pi_delay = '0;
    logic           pi_valid = 1'b0;
    logic [DW-1:0]  pi_data = '0;
    logic           po_in_ready, po_valid;
    logic [DW-1:0]  po_data;
    logic [CHW-1:0] po_ch;
    logic           pi_out_ready = 1'b1;

    echo_delay_fifo #(
        .DATA_WIDTH (DW), .MEM_DEPTH (MD), .NUM_CH (NCH),
        .ADDR_WIDTH (AW), .CH_WIDTH (CHW), .FB_SHIFT (FB)
    ) dut (
        .pi_clk       (pi_clk),
        .pi_rst_n     (pi_rst_n),
        .pi_flush     (pi_flush),
        .pi_delay     (pi_delay),
        .pi_valid     (pi_valid),
        .pi_data      (pi_data),
        .po_in_ready  (po_in_ready),
        .po_valid     (po_valid),
        .po_data      (po_data),
        .po_ch        (po_ch),
        .pi_out_ready (pi_out_ready)
    );

    always #5 pi_clk = ~pi_clk;

    typedef struct packed {
        logic [DW-1:0]  d;
        logic [CHW-1:0] ch;
    } exp_t;

    int   n_cmp = 0;
    int   n_fail = 0;
    exp_t q[$];     // outputs promised but not yet taken downstream
    exp_t log_q[$]; // outputs taken downstream, for directed checks
    int   hist[$];  // values stored into the line this epoch
    int   n = 0;    // accepts this epoch
    int   dm = 0;   // delay in samples this epoch
    bit   idle = 1'b1;

    task automatic chk(input logic [31:0] act, input logic [31:0] exp, input string tag);
        n_cmp++;
        assert (act === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    function automatic int calc_d(input int dly);
        int e, p;
        e = dly;
`ifdef ECHO_DELAY_FEEDBACK_EN
        if (e == 0) e = 1;
`endif
        p = e * NCH;
        return (p > MD - NCH) ? MD - NCH : p;
    endfunction

    function automatic int sat16(input int v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    task automatic model_reset();
        q.delete(); hist.delete(); n = 0; idle = 1'b1;
    endtask

    task automatic model_accept(input logic [DW-1:0] x);
        int xi, y, st;
        exp_t e;
        if (idle) begin dm = calc_d(int'(pi_delay)); idle = 1'b0; end
        xi = int'($signed(x));
`ifdef ECHO_DELAY_FEEDBACK_EN
        y  = (n < dm) ? 0 : hist[n - dm];
        st = sat16(xi + (y >>> FB));
`else
        y  = (dm == 0) ? xi : ((n < dm) ? 0 : hist[n - dm]);
        st = xi;
`endif
        hist.push_back(st);
        e.d  = DW'(y);
        e.ch = CHW'(n % NCH);
        q.push_back(e);
        n++;
    endtask

    // One clock: drive, check at negedge against the model, advance.
    task automatic cyc(input logic v, input logic [DW-1:0] d, input logic ordy, input logic fl);
        logic exp_rdy;
        pi_valid = v; pi_data = d; pi_out_ready = ordy; pi_flush = fl;
        @(negedge pi_clk);
        exp_rdy = !fl && (q.size() == 0 || ordy);
        chk(32'(po_in_ready), 32'(exp_rdy), "in_ready");
        chk(32'(po_valid), 32'(q.size() != 0), "valid");
        if (q.size() != 0) begin
            chk(32'(po_data), 32'(q[0].d), "data");
            chk(32'(po_ch), 32'(q[0].ch), "ch");
            if (ordy) begin log_q.push_back(q[0]); void'(q.pop_front()); end
        end
        if (fl) model_reset();
        else if (v && exp_rdy) model_accept(d);
        @(posedge pi_clk); #1;
    endtask

    task automatic drain();
        repeat (3) cyc(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic mid_reset(input string tag);
        #3 pi_rst_n = 1'b0;
        #1;
        chk(32'(po_valid), 0, {tag, "_valid"});
        chk(32'(po_data), 0, {tag, "_data"});
        chk(32'(po_ch), 0, {tag, "_ch"});
        chk(32'(po_in_ready), 1, {tag, "_in_ready"});
        model_reset();
        @(posedge pi_clk); #1;
        pi_rst_n = 1'b1;
    endtask

    initial begin
        int guard;
        // 1. reset state
        repeat (2) @(posedge pi_clk);
        #1;
        chk(32'(po_valid), 0, "rst_valid");
        chk(32'(po_data), 0, "rst_data");
        chk(32'(po_ch), 0, "rst_ch");
        chk(32'(po_in_ready), 1, "rst_in_ready");
        pi_rst_n = 1'b1;
        repeat (3) cyc(1'b0, '0, 1'b1, 1'b0);

        // 2. delay 3 frames, ramp
        pi_delay = 6'd3;
        log_q.delete();
        for (int i = 1; i <= 12; i++) cyc(1'b1, DW'(i), 1'b1, 1'b0);
        drain();
        for (int i = 0; i < 6; i++) chk(32'(log_q[i].d), 0, "t2_silence");
        chk(32'(log_q[6].d), 1, "t2_out7");
        chk(32'(log_q[6].ch), 0, "t2_ch7");
        chk(32'(log_q[7].d), 2, "t2_out8");
        chk(32'(log_q[7].ch), 1, "t2_ch8");

        // 3. zero delay bypass
        pi_delay = 6'd0;
        cyc(1'b0, '0, 1'b1, 1'b1);
        cyc(1'b1, 16'h1234, 1'b1, 1'b0);
        chk(32'(po_data), 32'h1234, "t3_bypass");
        drain();

        // 4. random stream with stalls, 3*MEM_DEPTH accepts, pointer wrap
        pi_delay = 6'd5;
        cyc(1'b0, '0, 1'b1, 1'b1);
        guard = 0;
        while (n < 3 * MD && guard < 5000) begin
            if (n == 40) begin
                cyc(1'b1, DW'($urandom), 1'b1, 1'b0);
                repeat (5) cyc(1'b1, DW'($urandom), 1'b0, 1'b0);
            end
            pi_delay = AW'($urandom_range(0, 63));
            cyc($urandom_range(0, 4) != 0, DW'($urandom), $urandom_range(0, 3) != 0, 1'b0);
            guard++;
        end
        chk(32'(n >= 3 * MD), 1, "t4_budget");
        drain();

        // 5. flush with valid high, delay 3 -> 1
        pi_delay = 6'd3;
        cyc(1'b0, '0, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) cyc(1'b1, DW'($urandom), 1'b1, 1'b0);
        pi_delay = 6'd1;
        cyc(1'b1, 16'hDEAD, 1'b1, 1'b1);
        log_q.delete();
        for (int i = 1; i <= 6; i++) cyc(1'b1, DW'(16'h100 + i), 1'b1, 1'b0);
        drain();
        chk(32'(log_q[0].d), 0, "t5_zero0");
        chk(32'(log_q[1].d), 0, "t5_zero1");
        chk(32'(log_q[2].d), 32'h101, "t5_first");
        chk(32'(log_q[3].d), 32'h102, "t5_second");

        // delay clamp at MEM_DEPTH-NUM_CH
        pi_delay = 6'd63;
        cyc(1'b0, '0, 1'b1, 1'b1);
        log_q.delete();
        for (int i = 0; i < 70; i++) cyc(1'b1, DW'(16'h200 + i), 1'b1, 1'b0);
        drain();
        chk(32'(log_q[MD - NCH - 1].d), 0, "clamp_last_zero");
        chk(32'(log_q[MD - NCH].d), 32'h200, "clamp_first");

`ifdef ECHO_DELAY_FEEDBACK_EN
        // 6. feedback impulse and saturation
        pi_delay = 6'd1;
        cyc(1'b0, '0, 1'b1, 1'b1);
        log_q.delete();
        cyc(1'b1, 16'h4000, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) cyc(1'b1, '0, 1'b1, 1'b0);
        drain();
        chk(32'(log_q[0].d), 0, "fb_imp0");
        chk(32'(log_q[2].d), 32'h4000, "fb_imp1");
        chk(32'(log_q[4].d), 32'h2000, "fb_imp2");
        chk(32'(log_q[6].d), 32'h1000, "fb_imp3");
        cyc(1'b0, '0, 1'b1, 1'b1);
        log_q.delete();
        for (int i = 0; i < 12; i++) cyc(1'b1, 16'h7FFF, 1'b1, 1'b0);
        drain();
        chk(32'(log_q[4].d), 32'h7FFF, "fb_sat");
        chk(32'(log_q[10].d), 32'h7FFF, "fb_sat_late");
`endif

        // 1b. async reset in the middle of RUN
        pi_delay = 6'd2;
        cyc(1'b0, '0, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) cyc(1'b1, DW'($urandom), 1'b1, 1'b0);
        pi_valid = 1'b0;
        mid_reset("mid_rst");
        repeat (3) cyc(1'b0, '0, 1'b1, 1'b0);
        pi_delay = 6'd0;
        cyc(1'b1, 16'h0BEE, 1'b1, 1'b0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
